// File: rtl/deserializer_if.sv
// rtl/deserializer_if.sv - serial bit input and assembled-word handshake bundle for the deserializer
interface deserializer_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic            data_in;
    logic            write_in;
    logic            ack_in;
    logic [WIDTH-1:0] data_out;
    logic            data_ready;
    logic            status_out;
    logic [CW-1:0]   bit_count_out;

    // Sender and queue side: drives serial bits and the ack back.
    modport master (
        output data_in,
        output write_in,
        output ack_in,
        input  data_out,
        input  data_ready,
        input  status_out,
        input  bit_count_out
    );

    modport slave (
        input  data_in,
        input  write_in,
        input  ack_in,
        output data_out,
        output data_ready,
        output status_out,
        output bit_count_out
    );
endinterface

// File: rtl/deserializer.sv
// rtl/deserializer.sv - MSB-first serial-to-parallel word assembler with ready/ack word handoff
module deserializer #(
    parameter int WIDTH = 8
) (
    input  logic           clock,
    input  logic           reset,
    deserializer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    // One-hot pair so that a corrupted register has a detectable illegal value.
    typedef enum logic [1:0] {
        RECEIVING = 2'b01,
        WAIT_ACK  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    // Holds only the first WIDTH-1 bits; the last bit goes straight into data_out.
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RECEIVING;
            shift_q <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        data_d  = data_q;
        case (state_q)
            RECEIVING: begin
                if (bus.write_in) begin
                    if (count_q == CW'(WIDTH - 1)) begin
                        data_d  = {shift_q, bus.data_in};
                        shift_d = '0;
                        count_d = '0;
                        state_d = WAIT_ACK;
                    end else begin
                        shift_d = {shift_q[WIDTH-3:0], bus.data_in};
                        count_d = count_q + 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                // Serial bits offered here are dropped, including on the ack edge.
                count_d = '0;
                if (bus.ack_in) begin
                    state_d = RECEIVING;
                end
            end
            default: begin
                state_d = RECEIVING;
                shift_d = '0;
                count_d = '0;
            end
        endcase
    end

    assign bus.data_out      = data_q;
    assign bus.data_ready    = (state_q == WAIT_ACK);
    assign bus.status_out    = (state_q == RECEIVING);
    assign bus.bit_count_out = count_q;
endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - randomized self-checking bench for deserializer against a bit-queue model
module tb_deserializer;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH) + 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    deserializer_if #(.WIDTH(WIDTH)) dif ();

    deserializer #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dif.slave)
    );

    // Reference model: bits collected so far, the last completed word, and whether it is pending.
    int               m_bits[$];
    logic [WIDTH-1:0] m_word;
    logic             m_ready;

    function automatic void model_reset();
        m_bits.delete();
        m_word  = '0;
        m_ready = 1'b0;
    endfunction

    function automatic void model_edge(input logic w, input logic d, input logic a);
        if (m_ready) begin
            if (a) m_ready = 1'b0;
        end else if (w) begin
            m_bits.push_back(int'(d));
            if (m_bits.size() == WIDTH) begin
                m_word = '0;
                foreach (m_bits[i]) m_word = (m_word << 1) | WIDTH'(m_bits[i]);
                m_bits.delete();
                m_ready = 1'b1;
            end
        end
    endfunction

    // Applies inputs, clocks one edge, updates the model; outputs are then stable at edge+1.
    task automatic drive_cycle(input logic w, input logic d, input logic a);
        dif.write_in = w;
        dif.data_in  = d;
        dif.ack_in   = a;
        @(posedge clock);
        #1;
        model_edge(w, d, a);
        dif.write_in = 1'b0;
        dif.ack_in   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        dif.write_in = 1'b0;
        dif.data_in  = 1'b0;
        dif.ack_in   = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({dif.status_out, dif.data_ready, dif.data_out, dif.bit_count_out} !== {1'b1, 1'b0, 8'h00, CW'(0)}) begin
            errors++;
            $display("FAIL reset: status=%0b ready=%0b data=%h count=%0d, required 1 0 00 0",
                     dif.status_out, dif.data_ready, dif.data_out, dif.bit_count_out);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, w[7-i], 1'b0);
            if (i < 7) begin
                checks++;
                if (dif.bit_count_out !== CW'(i + 1) || dif.data_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL single_count: bit %0d count=%0d ready=%0b, required %0d 0",
                             i, dif.bit_count_out, dif.data_ready, i + 1);
                end
            end
        end
        checks++;
        if ({dif.data_out, dif.data_ready, dif.status_out, dif.bit_count_out} !== {8'hA5, 1'b1, 1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL single_word: data=%h ready=%0b status=%0b count=%0d, required a5 1 0 0",
                     dif.data_out, dif.data_ready, dif.status_out, dif.bit_count_out);
        end
        drive_cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if ({dif.data_ready, dif.status_out, dif.data_out} !== {1'b0, 1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL single_ack: ready=%0b status=%0b data=%h, required 0 1 a5",
                     dif.data_ready, dif.status_out, dif.data_out);
        end
    endtask

    task automatic test_gapped();
        logic [7:0] w = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            int gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                drive_cycle(1'b0, 1'($urandom), 1'($urandom));
                checks++;
                if (dif.bit_count_out !== CW'(m_bits.size()) || dif.bit_count_out !== CW'(i)) begin
                    errors++;
                    $display("FAIL gapped_idle: count=%0d, required %0d", dif.bit_count_out, i);
                end
            end
            drive_cycle(1'b1, w[7-i], 1'b0);
        end
        checks++;
        if ({dif.data_out, dif.data_ready} !== {8'h3C, 1'b1}) begin
            errors++;
            $display("FAIL gapped_word: data=%h ready=%0b, required 3c 1", dif.data_out, dif.data_ready);
        end
        drive_cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [7:0] w = 8'h01;
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'($urandom), 1'($urandom), 1'b0);
            checks++;
            if ({dif.data_out, dif.data_ready, dif.status_out, dif.bit_count_out} !== {8'hFF, 1'b1, 1'b0, CW'(0)}) begin
                errors++;
                $display("FAIL backpressure_hold: cycle %0d data=%h ready=%0b status=%0b count=%0d, required ff 1 0 0",
                         i, dif.data_out, dif.data_ready, dif.status_out, dif.bit_count_out);
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, w[7-i], 1'b0);
        checks++;
        if ({dif.data_out, dif.data_ready} !== {8'h01, 1'b1}) begin
            errors++;
            $display("FAIL backpressure_next: data=%h ready=%0b, required 01 1", dif.data_out, dif.data_ready);
        end
    endtask

    task automatic test_ack_write_same_edge();
        logic [7:0] w = 8'($urandom);
        // Previous task left a word pending; ack together with a strobe carrying a 1.
        drive_cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if ({dif.bit_count_out, dif.status_out, dif.data_ready} !== {CW'(0), 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ack_write_drop: count=%0d status=%0b ready=%0b, required 0 1 0",
                     dif.bit_count_out, dif.status_out, dif.data_ready);
        end
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, w[7-i], 1'b0);
        checks++;
        if ({dif.data_out, dif.data_ready} !== {w, 1'b1} || m_word !== w) begin
            errors++;
            $display("FAIL ack_write_next: data=%h ready=%0b, required %h 1", dif.data_out, dif.data_ready, w);
        end
        drive_cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        logic [7:0] w = 8'h81;
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({dif.status_out, dif.data_ready, dif.data_out, dif.bit_count_out} !== {1'b1, 1'b0, 8'h00, CW'(0)}) begin
            errors++;
            $display("FAIL async_reset: status=%0b ready=%0b data=%h count=%0d, required 1 0 00 0",
                     dif.status_out, dif.data_ready, dif.data_out, dif.bit_count_out);
        end
        #1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, w[7-i], 1'b0);
        checks++;
        if ({dif.data_out, dif.data_ready} !== {8'h81, 1'b1}) begin
            errors++;
            $display("FAIL async_reset_word: data=%h ready=%0b, required 81 1", dif.data_out, dif.data_ready);
        end
        drive_cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic w = ($urandom_range(0, 3) != 0);
            logic a = ($urandom_range(0, 2) == 0);
            drive_cycle(w, 1'($urandom), a);
            checks++;
            if ({dif.data_out, dif.data_ready, dif.status_out, dif.bit_count_out} !==
                {m_word, m_ready, ~m_ready, CW'(m_bits.size())}) begin
                errors++;
                $display("FAIL random: cycle %0d data=%h ready=%0b status=%0b count=%0d, required %h %0b %0b %0d",
                         i, dif.data_out, dif.data_ready, dif.status_out, dif.bit_count_out,
                         m_word, m_ready, ~m_ready, m_bits.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_gapped();
        test_backpressure();
        test_ack_write_same_edge();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
Serial-to-parallel front end of the deserializer datapath. It receives a 1-bit stream qualified by write_in and assembles WIDTH-bit words MSB-first. Each completed word is offered to the downstream word queue through a ready/ack handshake. Target operating clock is 10 kHz; the design has no frequency-specific logic.

Parameters:
WIDTH, 8, bits per assembled word; must match the queue word width.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
data_in  input  1  serial data bit; sampled only when write_in=1 and status_out=1.
write_in  input  1  sender strobe: one bit transferred per clock with write_in=1.
ack_in  input  1  downstream (queue) accepted data_out; sampled only while data_ready=1.
data_out  output  WIDTH  assembled word; stable while data_ready=1.
data_ready  output  1  data_out holds a valid, unacknowledged word; drives the queue enqueue strobe.
status_out  output  1  block can accept serial bits (1 = receiving).
bit_count_out  output  log2(WIDTH)+1  bits collected in the current word (0..WIDTH-1).

Behaviour:
- Reset (reset=0, asynchronous): state=RECEIVING, shift register=0, bit count=0, data_out=0, data_ready=0, status_out=1, bit_count_out=0. Release is synchronous to clock.
- State RECEIVING (status_out=1, data_ready=0):
  - write_in=1: shift={shift[WIDTH-2:0], data_in}; count+1.
  - The first bit received ends up in data_out[WIDTH-1] (MSB-first).
  - write_in=0: hold state and count.
  - Bit WIDTH of the word accepted at edge N: at edge N, data_out <= complete word, data_ready <= 1, status_out <= 0, count <= 0, state -> WAIT_ACK. There are no extra latency cycles.
- State WAIT_ACK (status_out=0, data_ready=1):
  - data_out holds the word unchanged.
  - write_in is ignored; bits presented here are dropped and do not enter the shift register.
  - ack_in=1 at edge M: data_ready <= 0, status_out <= 1, state -> RECEIVING. The first new bit can be accepted at edge M+1; write_in at edge M is still ignored.
  - ack_in=0: stay, indefinitely. This covers backpressure while the queue is full (len=8), since the queue withholds ack.
- ack_in while in RECEIVING: ignored.
- data_out after ack: retains the last word until the next word completes. Consumers must qualify with data_ready.
- bit_count_out: mirrors the internal count; it reads 0 in WAIT_ACK.
- Reset mid-word or in WAIT_ACK: the partial word or the pending word is discarded, and all outputs return to their reset values immediately.
- States are encoded as a 2-state FSM; any illegal encoding recovers to RECEIVING.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, then release -> status_out=1, data_ready=0, data_out=8'h00, bit_count_out=0.
2. Single word: write_in=1 for 8 cycles with bits 1,0,1,0,0,1,0,1 -> at the 8th edge data_out=8'hA5, data_ready=1, status_out=0. ack_in=1 for one cycle -> next edge data_ready=0, status_out=1.
3. Gapped input: bits of 8'h3C with write_in=0 idle cycles interleaved -> bit_count_out steps 0..7 only on strobe cycles, and data_out=8'h3C after the 8th strobe.
4. Backpressure: complete 8'hFF, hold ack_in=0 for 20 cycles while toggling write_in/data_in -> data_out stays 8'hFF, data_ready=1, count stays 0. Then ack_in=1 -> the next 8 bits form 8'h01 correctly.
5. Ack/write same edge: assert ack_in and write_in together in WAIT_ACK -> that bit is dropped, bit_count_out=0 afterwards, and the next word assembles from subsequent bits.
6. Async reset mid-word: after 5 bits, pulse reset=0 between clock edges -> outputs reset immediately, and a following full word 8'h81 assembles with no residue of the partial word.
